// File: rtl/pll_clk_gen_pkg.sv
// Shared limits and elaboration-time helpers for the PLL stand-in.
package pll_clk_gen_pkg;

  localparam int unsigned PLL_DIV_MAX   = 256;
  localparam int unsigned PLL_LOCK_MAX  = 65535;

  // Legal ratios: 1 (bypass) or an even value in 2..PLL_DIV_MAX.
  function automatic bit pll_div_legal(input int unsigned div);
    return (div == 1) || ((div >= 2) && (div <= PLL_DIV_MAX) && (div % 2 == 0));
  endfunction

  // Lock counter width: clog2(cycles+1), never below 1.
  function automatic int unsigned pll_lock_w(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Divider counter width for a half period of `half` edges, never below 1.
  function automatic int unsigned pll_div_cnt_w(input int unsigned half);
    return (half <= 1) ? 1 : $clog2(half);
  endfunction

endpackage

// File: rtl/pll_clk_gen_lock_timer.sv
// Saturating lock counter and sticky locked flag.
module pll_lock_timer
  import pll_clk_gen_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic inclk0,
  input  logic areset,
  output logic locked
);

  localparam int unsigned LOCK_W = pll_lock_w(LOCK_CYCLES);

  logic [LOCK_W-1:0] r_cnt;
  logic              r_locked;
  logic              w_cnt_full;

  assign w_cnt_full = (r_cnt == LOCK_W'(LOCK_CYCLES));

  // Count edges since reset release, saturating at LOCK_CYCLES.
  always_ff @(posedge inclk0) begin
    if (areset) begin
      r_cnt <= '0;
    end else if (!w_cnt_full) begin
      r_cnt <= r_cnt + LOCK_W'(1);
    end
  end

  // Set locked on the edge that observes a full count; hold until reset.
  always_ff @(posedge inclk0) begin
    if (areset) begin
      r_locked <= 1'b0;
    end else if (w_cnt_full) begin
      r_locked <= 1'b1;
    end
  end

  assign locked = r_locked;

endmodule

// File: rtl/pll_clk_gen.sv
// Digital PLL stand-in: bypassed or even-divided c0 plus a lock flag.
module pll_clk_gen
  import pll_clk_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic inclk0,
  input  logic areset,
  output logic c0,
  output logic locked
);

  // Reject illegal configurations at elaboration.
  if (!pll_div_legal(CLK_DIV)) begin : g_bad_div
    $fatal(1, "pll_clk_gen: CLK_DIV=%0d must be 1 or even in 2..256", CLK_DIV);
  end
  if (LOCK_CYCLES > PLL_LOCK_MAX) begin : g_bad_lock
    $fatal(1, "pll_clk_gen: LOCK_CYCLES=%0d exceeds 65535", LOCK_CYCLES);
  end

  if (CLK_DIV == 1) begin : g_bypass
    // Bypass: c0 is the reference clock itself, independent of reset.
    assign c0 = inclk0;
  end else begin : g_divide
    localparam int unsigned HALF  = CLK_DIV / 2;
    localparam int unsigned CNT_W = pll_div_cnt_w(HALF);

    logic [CNT_W-1:0] r_cnt;
    logic             r_c0;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(HALF - 1));

    // Half-period counter; toggle the output flop on each wrap.
    always_ff @(posedge inclk0) begin
      if (areset) begin
        r_cnt <= '0;
        r_c0  <= 1'b0;
      end else if (w_wrap) begin
        r_cnt <= '0;
        r_c0  <= ~r_c0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    // Flop drives the pin directly so the generated clock cannot glitch.
    assign c0 = r_c0;
  end

  pll_lock_timer #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock (
    .inclk0 (inclk0),
    .areset (areset),
    .locked (locked)
  );

endmodule

// File: tb/tb_pll_clk_gen.sv
// Self-checking bench for pll_clk_gen across divide, bypass and lock settings.
module tb_pll_clk_gen;

  logic inclk0;
  logic areset;
  logic c0_d2, c0_d8, c0_byp, c0_lc0;
  logic lk_d2, lk_d8, lk_byp, lk_lc0;

  int n_total;
  int n_pass;
  int edge_k;

  typedef struct {
    int   edge_n;
    logic c0_d2;
    logic c0_d8;
    logic lk16;
    logic lk0;
  } vec_t;

  vec_t vecs[11];

  pll_clk_gen #(.CLK_DIV(2), .LOCK_CYCLES(16)) u_d2 (
    .inclk0(inclk0), .areset(areset), .c0(c0_d2), .locked(lk_d2));
  pll_clk_gen #(.CLK_DIV(8), .LOCK_CYCLES(16)) u_d8 (
    .inclk0(inclk0), .areset(areset), .c0(c0_d8), .locked(lk_d8));
  pll_clk_gen #(.CLK_DIV(1), .LOCK_CYCLES(16)) u_byp (
    .inclk0(inclk0), .areset(areset), .c0(c0_byp), .locked(lk_byp));
  pll_clk_gen #(.CLK_DIV(2), .LOCK_CYCLES(0)) u_lc0 (
    .inclk0(inclk0), .areset(areset), .c0(c0_lc0), .locked(lk_lc0));

  initial inclk0 = 1'b0;
  always #10 inclk0 = ~inclk0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s edge=%0d got=%0d expected=%0d", name, edge_k, act, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge inclk0);
    #1;
    edge_k++;
  endtask

  // Check bypass output on the low phase as well.
  task automatic chk_byp_low();
    @(negedge inclk0);
    #1;
    chk("byp_c0_low", int'(c0_byp), 0);
  endtask

  task automatic run_table();
    for (int i = 0; i < 11; i++) begin
      while (edge_k < vecs[i].edge_n) tick();
      chk("d2_c0",    int'(c0_d2),  int'(vecs[i].c0_d2));
      chk("d8_c0",    int'(c0_d8),  int'(vecs[i].c0_d8));
      chk("d2_lock",  int'(lk_d2),  int'(vecs[i].lk16));
      chk("d8_lock",  int'(lk_d8),  int'(vecs[i].lk16));
      chk("byp_lock", int'(lk_byp), int'(vecs[i].lk16));
      chk("lc0_lock", int'(lk_lc0), int'(vecs[i].lk0));
      chk("lc0_c0",   int'(c0_lc0), int'(vecs[i].c0_d2));
      chk("byp_c0_high", int'(c0_byp), 1);
    end
  endtask

  initial begin
    int errs;
    int highs;
    int bad_lock;
    int bad_cnt;
    n_total = 0;
    n_pass  = 0;
    edge_k  = 0;

    //               edge d2  d8  lk16 lk0
    vecs[0]  = '{ 1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{ 2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{ 3, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{ 4, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{ 7, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{ 8, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{12, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{16, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{17, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{20, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{33, 1'b1, 1'b0, 1'b1, 1'b1};

    // Initial reset for three edges.
    areset = 1'b1;
    repeat (3) tick();
    chk("rst_d2_c0",   int'(c0_d2), 0);
    chk("rst_d8_c0",   int'(c0_d8), 0);
    chk("rst_d2_lock", int'(lk_d2), 0);
    chk("rst_lc0_lock", int'(lk_lc0), 0);
    chk("rst_byp_c0_high", int'(c0_byp), 1);
    chk_byp_low();

    @(posedge inclk0);
    #1;
    areset = 1'b0;
    edge_k = 0;
    run_table();
    chk_byp_low();

    // Mid-operation reset with c0=1 and locked=1.
    while (edge_k < 35) tick();
    chk("pre_d2_c0",   int'(c0_d2), 1);
    chk("pre_d2_lock", int'(lk_d2), 1);
    areset = 1'b1;
    tick();
    chk("mid_d2_c0",    int'(c0_d2), 0);
    chk("mid_d8_c0",    int'(c0_d8), 0);
    chk("mid_d2_lock",  int'(lk_d2), 0);
    chk("mid_byp_lock", int'(lk_byp), 0);
    chk("mid_lc0_lock", int'(lk_lc0), 0);
    chk("mid_byp_c0_high", int'(c0_byp), 1);
    chk_byp_low();
    @(posedge inclk0);
    #1;
    areset = 1'b0;
    edge_k = 0;
    run_table();

    // Divide-by-8 waveform and duty over 10 output periods.
    errs  = 0;
    highs = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (c0_d8 !== 1'(((edge_k / 4) % 2))) errs++;
      if (c0_d8 === 1'b1) highs++;
    end
    chk("d8_wave_errs", errs, 0);
    chk("d8_duty_highs", highs, 40);

    // Extended run: locked holds and the lock counter stays saturated.
    bad_lock = 0;
    bad_cnt  = 0;
    for (int i = 0; i < 20000; i++) begin
      tick();
      if (lk_d2 !== 1'b1 || lk_d8 !== 1'b1 || lk_byp !== 1'b1 || lk_lc0 !== 1'b1) bad_lock++;
      if (int'(u_d2.u_lock.r_cnt) != 16) bad_cnt++;
    end
    chk("long_lock_drops", bad_lock, 0);
    chk("long_cnt_unsat", bad_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
